// File: rtl/reg_scoreboard.sv
// Purpose: per-register in-flight write tracker (EX/MEM/WB stage mask + load flag) for the 5-stage RV32I core.
// Latency: o_stall is combinational from held state; o_fwd_a/o_fwd_b/o_busy reflect state one edge after issue.
// Backpressure: i_pipe_en = 0 freezes every flop; o_stall is still evaluated from the frozen state.
//
// Ports:
//   i_clk, i_rst            - core clock, synchronous active-high reset
//   i_pipe_en, i_ex_flush   - global advance enable, EX-resolved branch squash
//   i_id_*                  - ID-stage instruction: valid, rd write/load/address, rs1/rs2 use and address
//   o_stall                 - load-use stall for the ID instruction
//   o_fwd_a, o_fwd_b        - registered EX operand selects (10 = MEM, 01 = WB, 00 = regfile)
//   o_busy                  - per-register "write in flight" flags
module reg_scoreboard #(
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_pipe_en,
  input  logic            i_ex_flush,
  input  logic            i_id_valid,
  input  logic            i_id_rd_wren,
  input  logic            i_id_is_load,
  input  logic [AW-1:0]   i_id_rd_addr,
  input  logic            i_id_is_rs1,
  input  logic [AW-1:0]   i_id_rs1_addr,
  input  logic            i_id_is_rs2,
  input  logic [AW-1:0]   i_id_rs2_addr,
  output logic            o_stall,
  output logic [1:0]      o_fwd_a,
  output logic [1:0]      o_fwd_b,
  output logic [NREG-1:0] o_busy
);

  // stg bit0 = writer in EX, bit1 = in MEM, bit2 = in WB; ld marks the same slots for loads.
  logic [NREG-1:0][2:0] stg_q, stg_d;
  logic [NREG-1:0][2:0] ld_q,  ld_d;
  logic [1:0]           fwd_a_q, fwd_a_d;
  logic [1:0]           fwd_b_q, fwd_b_d;

  logic [NREG-1:0] rd_dec;
  logic [1:0]      rs1_stg, rs2_stg;
  logic            rs1_ld, rs2_ld;
  logic            hit1, hit2, stall, issue, id_adv;
  logic            rs1_used, rs2_used;
  // The load flag of a WB writer only shifts out; it never influences a decision.
  logic [NREG-1:0] ld_wb_unused;

  // Youngest writer wins: EX producer will sit in MEM when the consumer reaches EX.
  function automatic logic [1:0] fwd_sel(input logic [1:0] s);
    if (s[0])      return 2'b10;
    else if (s[1]) return 2'b01;
    else           return 2'b00;
  endfunction

  always_comb begin
    rs1_stg  = stg_q[i_id_rs1_addr][1:0];
    rs2_stg  = stg_q[i_id_rs2_addr][1:0];
    rs1_ld   = ld_q[i_id_rs1_addr][0];
    rs2_ld   = ld_q[i_id_rs2_addr][0];
    rs1_used = i_id_is_rs1 & (i_id_rs1_addr != '0);
    rs2_used = i_id_is_rs2 & (i_id_rs2_addr != '0);

    // Only a load still in EX is unforwardable into the next EX.
    hit1  = rs1_used & rs1_stg[0] & rs1_ld;
    hit2  = rs2_used & rs2_stg[0] & rs2_ld;
    // A flush squashes the consumer, so it must never stall.
    stall = (hit1 | hit2) & i_id_valid & ~i_ex_flush;

    issue  = i_id_valid & i_id_rd_wren & (i_id_rd_addr != '0) & ~stall & ~i_ex_flush;
    id_adv = i_id_valid & ~stall & ~i_ex_flush;
    rd_dec = issue ? ({{(NREG-1){1'b0}}, 1'b1} << i_id_rd_addr) : '0;
  end

  always_comb begin
    stg_d        = stg_q;
    ld_d         = ld_q;
    fwd_a_d      = fwd_a_q;
    fwd_b_d      = fwd_b_q;
    ld_wb_unused = '0;
    for (int r = 0; r < NREG; r++) begin
      ld_wb_unused[r] = ld_q[r][2];
    end
    if (i_pipe_en) begin
      // Each writer keeps its own slot, so back-to-back writers to one rd coexist.
      // The flush kills only the EX slot; bit2 falls off as the WB write retires.
      for (int r = 0; r < NREG; r++) begin
        stg_d[r] = {stg_q[r][1], stg_q[r][0] & ~i_ex_flush, rd_dec[r]};
        ld_d[r]  = {ld_q[r][1],  ld_q[r][0]  & ~i_ex_flush, rd_dec[r] & i_id_is_load};
      end
      // A bubble enters EX whenever ID does not advance.
      fwd_a_d = (id_adv & rs1_used) ? fwd_sel(rs1_stg) : 2'b00;
      fwd_b_d = (id_adv & rs2_used) ? fwd_sel(rs2_stg) : 2'b00;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stg_q   <= '0;
      ld_q    <= '0;
      fwd_a_q <= 2'b00;
      fwd_b_q <= 2'b00;
    end else begin
      stg_q   <= stg_d;
      ld_q    <= ld_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  always_comb begin
    o_busy = '0;
    for (int r = 0; r < NREG; r++) begin
      o_busy[r] = |stg_q[r];
    end
  end

  assign o_stall = stall;
  assign o_fwd_a = fwd_a_q;
  assign o_fwd_b = fwd_b_q;

endmodule
